// File: rtl/vj_cascade_seq.sv
// Sequential Viola-Jones cascade evaluator: accepts one integral window per handshake,
// walks the feature ROM one descriptor per cycle and exits on the first failing stage.
module vj_cascade_seq #(
  parameter int unsigned WIN         = 24,
  parameter int unsigned NUM_STAGE   = 25,
  parameter int unsigned NUM_FEATURE = 2913,
  parameter int unsigned PYR_W       = 4,
  parameter int unsigned CW          = 5,
  parameter int unsigned FA_W        = 12
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIN:0][WIN:0][31:0] in_win,
  input  logic [31:0]               in_std_dev,
  input  logic [1:0][31:0]          in_coord,
  input  logic [PYR_W-1:0]          in_pyr,
  output logic                      feat_rd_en,
  output logic [FA_W-1:0]           feat_addr,
  input  logic [2:0][3:0][CW-1:0]   feat_rect,
  input  logic [2:0][31:0]          feat_weight,
  input  logic [31:0]               feat_thres,
  input  logic [31:0]               feat_above,
  input  logic [31:0]               feat_below,
  input  logic                      feat_last,
  input  logic [31:0]               stage_thres,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_face,
  output logic [7:0]                out_stages,
  output logic [31:0]               out_accum,
  output logic [1:0][31:0]          out_coord,
  output logic [PYR_W-1:0]          out_pyr,
  output logic                      out_err
);

  localparam logic [FA_W-1:0] LAST_ADDR = FA_W'(NUM_FEATURE - 1);
  localparam logic [7:0]      STAGE_MAX = 8'(NUM_STAGE);
  localparam logic [CW-1:0]   COORD_MAX = CW'(WIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_CHECK,
    S_DONE
  } state_e;

  state_e                    state_q, state_d;
  logic [WIN:0][WIN:0][31:0] win_q, win_d;
  logic [31:0]               std_q, std_d;
  logic [FA_W-1:0]           addr_q, addr_d;
  logic [31:0]               stage_sum_q, stage_sum_d;
  logic [31:0]               stage_thres_q, stage_thres_d;
  logic [31:0]               total_q, total_d;
  logic [7:0]                stages_q, stages_d;
  logic                      err_q, err_d;

  logic                      out_valid_q, out_valid_d;
  logic                      out_face_q, out_face_d;
  logic [7:0]                out_stages_q, out_stages_d;
  logic [31:0]               out_accum_q, out_accum_d;
  logic [1:0][31:0]          out_coord_q, out_coord_d;
  logic [PYR_W-1:0]          out_pyr_q, out_pyr_d;
  logic                      out_err_q, out_err_d;

  logic                      rd_en_c;
  logic [CW-1:0]             x1_c, y1_c, x2_c, y2_c;
  logic [31:0]               rect_v_c, fsum_c, tprod_c, acc_c;
  logic                      rect_err_c;
  logic                      pass_c, last_stage_c;
  logic [7:0]                stages_inc_c;
  logic [31:0]               total_inc_c;

  assign in_ready   = (state_q == S_IDLE) && !reset;
  assign feat_rd_en = rd_en_c && !reset;
  assign feat_addr  = addr_d;

  assign out_valid  = out_valid_q;
  assign out_face   = out_face_q;
  assign out_stages = out_stages_q;
  assign out_accum  = out_accum_q;
  assign out_coord  = out_coord_q;
  assign out_pyr    = out_pyr_q;
  assign out_err    = out_err_q;

  // Weak-classifier value of the descriptor currently on the ROM bus.
  always_comb begin
    x1_c       = '0;
    y1_c       = '0;
    x2_c       = '0;
    y2_c       = '0;
    rect_v_c   = '0;
    fsum_c     = '0;
    rect_err_c = 1'b0;
    for (int r = 0; r < 3; r++) begin
      x1_c = feat_rect[2'(r)][3];
      y1_c = feat_rect[2'(r)][2];
      x2_c = feat_rect[2'(r)][1];
      y2_c = feat_rect[2'(r)][0];
      if ((x1_c > COORD_MAX) || (y1_c > COORD_MAX) ||
          (x2_c > COORD_MAX) || (y2_c > COORD_MAX)) begin
        rect_v_c   = '0;
        rect_err_c = 1'b1;
      end else begin
        rect_v_c = win_q[y2_c][x2_c] + win_q[y1_c][x1_c]
                 - win_q[y1_c][x2_c] - win_q[y2_c][x1_c];
      end
      fsum_c = fsum_c + 32'(rect_v_c * feat_weight[2'(r)]);
    end
    tprod_c = 32'(feat_thres * std_q);
    acc_c   = ($signed(fsum_c) > $signed(tprod_c)) ? feat_above : feat_below;
  end

  // Stage decision terms used in CHECK.
  always_comb begin
    pass_c       = $signed(stage_sum_q) > $signed(stage_thres_q);
    stages_inc_c = stages_q + 8'd1;
    total_inc_c  = total_q + stage_sum_q;
    last_stage_c = (stages_inc_c == STAGE_MAX);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d       = state_q;
    win_d         = win_q;
    std_d         = std_q;
    addr_d        = addr_q;
    stage_sum_d   = stage_sum_q;
    stage_thres_d = stage_thres_q;
    total_d       = total_q;
    stages_d      = stages_q;
    err_d         = err_q;
    out_valid_d   = out_valid_q;
    out_face_d    = out_face_q;
    out_stages_d  = out_stages_q;
    out_accum_d   = out_accum_q;
    out_coord_d   = out_coord_q;
    out_pyr_d     = out_pyr_q;
    out_err_d     = out_err_q;
    rd_en_c       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          win_d       = in_win;
          std_d       = in_std_dev;
          out_coord_d = in_coord;
          out_pyr_d   = in_pyr;
          stage_sum_d = '0;
          total_d     = '0;
          stages_d    = '0;
          err_d       = 1'b0;
          rd_en_c     = 1'b1;
          addr_d      = '0;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        stage_sum_d = stage_sum_q + acc_c;
        if (rect_err_c) begin
          err_d = 1'b1;
        end
        if (feat_last || (addr_q == LAST_ADDR)) begin
          stage_thres_d = stage_thres;
          state_d       = S_CHECK;
        end else begin
          rd_en_c = 1'b1;
          addr_d  = addr_q + FA_W'(1);
        end
      end
      S_CHECK: begin
        if (pass_c) begin
          total_d  = total_inc_c;
          stages_d = stages_inc_c;
        end
        if (!pass_c || last_stage_c || (addr_q == LAST_ADDR)) begin
          out_valid_d  = 1'b1;
          out_face_d   = pass_c && last_stage_c;
          out_stages_d = pass_c ? stages_inc_c : stages_q;
          out_accum_d  = pass_c ? total_inc_c : total_q;
          out_err_d    = err_q;
          state_d      = S_DONE;
        end else begin
          stage_sum_d = '0;
          rd_en_c     = 1'b1;
          addr_d      = addr_q + FA_W'(1);
          state_d     = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers are reset; the latched window is data only.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      stage_sum_q   <= '0;
      stage_thres_q <= '0;
      total_q       <= '0;
      stages_q      <= '0;
      err_q         <= 1'b0;
      out_valid_q   <= 1'b0;
      out_face_q    <= 1'b0;
      out_stages_q  <= '0;
      out_accum_q   <= '0;
      out_coord_q   <= '0;
      out_pyr_q     <= '0;
      out_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      stage_sum_q   <= stage_sum_d;
      stage_thres_q <= stage_thres_d;
      total_q       <= total_d;
      stages_q      <= stages_d;
      err_q         <= err_d;
      out_valid_q   <= out_valid_d;
      out_face_q    <= out_face_d;
      out_stages_q  <= out_stages_d;
      out_accum_q   <= out_accum_d;
      out_coord_q   <= out_coord_d;
      out_pyr_q     <= out_pyr_d;
      out_err_q     <= out_err_d;
    end
  end

  always_ff @(posedge clock) begin
    win_q <= win_d;
    std_q <= std_d;
  end

endmodule

// File: tb/tb_vj_cascade_seq.sv
// Scoreboard bench for vj_cascade_seq: a synchronous ROM model, a loop-level cascade
// reference model, and a monitor that checks results, latency, read sequence and hold.
module tb_vj_cascade_seq;

  localparam int unsigned WIN   = 24;
  localparam int unsigned NS    = 2;
  localparam int unsigned NF    = 8;
  localparam int unsigned PYR_W = 4;
  localparam int unsigned CW    = 5;
  localparam int unsigned FA_W  = 3;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIN:0][WIN:0][31:0] in_win;
  logic [31:0]               in_std_dev;
  logic [1:0][31:0]          in_coord;
  logic [PYR_W-1:0]          in_pyr;
  logic                      feat_rd_en;
  logic [FA_W-1:0]           feat_addr;
  logic [2:0][3:0][CW-1:0]   feat_rect;
  logic [2:0][31:0]          feat_weight;
  logic [31:0]               feat_thres, feat_above, feat_below, stage_thres;
  logic                      feat_last;
  logic                      out_valid, out_ready, out_face, out_err;
  logic [7:0]                out_stages;
  logic [31:0]               out_accum;
  logic [1:0][31:0]          out_coord;
  logic [PYR_W-1:0]          out_pyr;

  vj_cascade_seq #(
    .WIN(WIN), .NUM_STAGE(NS), .NUM_FEATURE(NF), .PYR_W(PYR_W), .CW(CW), .FA_W(FA_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_win(in_win), .in_std_dev(in_std_dev),
    .in_coord(in_coord), .in_pyr(in_pyr),
    .feat_rd_en(feat_rd_en), .feat_addr(feat_addr), .feat_rect(feat_rect),
    .feat_weight(feat_weight), .feat_thres(feat_thres), .feat_above(feat_above),
    .feat_below(feat_below), .feat_last(feat_last), .stage_thres(stage_thres),
    .out_valid(out_valid), .out_ready(out_ready), .out_face(out_face),
    .out_stages(out_stages), .out_accum(out_accum), .out_coord(out_coord),
    .out_pyr(out_pyr), .out_err(out_err)
  );

  always #5 clock = ~clock;

  longint cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ROM contents and synchronous read port
  logic [2:0][3:0][CW-1:0] rom_rect [NF];
  logic [2:0][31:0]        rom_w    [NF];
  logic [31:0]             rom_thr  [NF];
  logic [31:0]             rom_abv  [NF];
  logic [31:0]             rom_blw  [NF];
  logic [31:0]             rom_sthr [NF];
  logic                    rom_last [NF];
  int                      rd_log[$];

  always @(posedge clock) begin
    if (feat_rd_en) begin
      feat_rect   <= rom_rect[feat_addr];
      feat_weight <= rom_w[feat_addr];
      feat_thres  <= rom_thr[feat_addr];
      feat_above  <= rom_abv[feat_addr];
      feat_below  <= rom_blw[feat_addr];
      feat_last   <= rom_last[feat_addr];
      stage_thres <= rom_sthr[feat_addr];
      rd_log.push_back(int'(feat_addr));
    end
  end

  // Reference model
  typedef struct {
    logic             face;
    logic [7:0]       stages;
    logic [31:0]      accum;
    logic             err;
    logic [1:0][31:0] coord;
    logic [PYR_W-1:0] pyr;
    int               nrd;
    int               lat;
    longint           vcyc;
  } exp_t;

  exp_t                      sb[$];
  logic [WIN:0][WIN:0][31:0] win_tb;
  logic [31:0]               std_tb;

  function automatic int feat_val(input int a, inout bit err);
    int fsum = 0;
    for (int r = 0; r < 3; r++) begin
      int x1 = int'(rom_rect[a][r][3]);
      int y1 = int'(rom_rect[a][r][2]);
      int x2 = int'(rom_rect[a][r][1]);
      int y2 = int'(rom_rect[a][r][0]);
      int v;
      if (x1 > int'(WIN) || y1 > int'(WIN) || x2 > int'(WIN) || y2 > int'(WIN)) begin
        v   = 0;
        err = 1'b1;
      end else begin
        v = int'(win_tb[y2][x2]) + int'(win_tb[y1][x1]) - int'(win_tb[y1][x2]) - int'(win_tb[y2][x1]);
      end
      fsum += v * int'(rom_w[a][r]);
    end
    return (fsum > int'(rom_thr[a]) * int'(std_tb)) ? int'(rom_abv[a]) : int'(rom_blw[a]);
  endfunction

  function automatic exp_t model();
    exp_t e;
    int a = 0, total = 0, st = 0, f = 0, s = 0, sum;
    bit pass = 1'b0, err = 1'b0;
    while (1) begin
      sum = 0;
      while (1) begin
        sum += feat_val(a, err);
        f++;
        if (rom_last[a] || a == int'(NF) - 1) break;
        a++;
      end
      s++;
      pass = sum > int'(rom_sthr[a]);
      if (pass) begin
        total += sum;
        st++;
      end
      if (!pass || st == int'(NS) || a == int'(NF) - 1) break;
      a++;
    end
    e.face   = pass && (st == int'(NS));
    e.stages = 8'(st);
    e.accum  = 32'(total);
    e.err    = err;
    e.coord  = '0;
    e.pyr    = '0;
    e.nrd    = a + 1;
    e.lat    = 1 + f + s;
    e.vcyc   = 0;
    return e;
  endfunction

  // Downstream back-pressure: hold out_ready low for stall_n cycles of each result
  int stall_n = 0;
  int stall_ctr = 0;
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        if (stall_ctr < stall_n) begin
          out_ready = 1'b0;
          stall_ctr++;
        end else begin
          out_ready = 1'b1;
        end
      end else begin
        out_ready = 1'b0;
        stall_ctr = 0;
      end
    end
  end

  // Monitor: compare each new result against the scoreboard head, then check hold
  longint        hs_cyc = 0;
  bit            prev_v = 1'b0;
  logic [109:0]  snap;
  initial begin
    exp_t cur;
    bit   ok;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_v = 1'b0;
      end else begin
        if (out_valid) begin
          if (!prev_v) begin
            if (sb.size() == 0) begin
              chk("unexpected_out_valid", 1, 0);
            end else begin
              cur = sb[0];
              chk("out_face", out_face, cur.face);
              chk("out_stages", out_stages, cur.stages);
              chk("out_accum", out_accum, cur.accum);
              chk("out_err", out_err, cur.err);
              chk("out_coord", out_coord, cur.coord);
              chk("out_pyr", out_pyr, cur.pyr);
              chk("latency", cyc, cur.vcyc);
              chk("rd_count", rd_log.size(), cur.nrd);
              ok = (rd_log.size() == cur.nrd);
              for (int i = 0; i < rd_log.size(); i++) if (rd_log[i] != i) ok = 1'b0;
              chk("rd_sequence", ok, 1);
              rd_log.delete();
            end
            snap = {out_face, out_stages, out_accum, out_coord, out_pyr, out_err};
          end else begin
            chk("hold_stable", {out_face, out_stages, out_accum, out_coord, out_pyr, out_err}, snap);
            chk("in_ready_in_done", in_ready, 0);
          end
          if (out_ready && sb.size() > 0) begin
            void'(sb.pop_front());
            hs_cyc = cyc;
          end
        end
        prev_v = out_valid;
      end
    end
  end

  // Stimulus helpers
  task automatic send(input logic [1:0][31:0] coord, input logic [PYR_W-1:0] pyr,
                      output longint acc_cyc);
    exp_t e;
    int   n = 0;
    e       = model();
    e.coord = coord;
    e.pyr   = pyr;
    acc_cyc = -1;
    @(negedge clock);
    in_win     = win_tb;
    in_std_dev = std_tb;
    in_coord   = coord;
    in_pyr     = pyr;
    in_valid   = 1'b1;
    while (!in_ready && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
    end else begin
      acc_cyc = cyc;
      e.vcyc  = cyc + longint'(e.lat);
      sb.push_back(e);
      @(negedge clock);
      in_valid   = 1'b0;
      in_std_dev = $urandom;
      for (int y = 0; y <= int'(WIN); y++)
        for (int x = 0; x <= int'(WIN); x++) in_win[y][x] = $urandom;
    end
  endtask

  task automatic send_rand();
    longint ac;
    logic [1:0][31:0] c;
    c[0] = $urandom;
    c[1] = $urandom;
    send(c, PYR_W'($urandom), ac);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (sb.size() != 0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      chk("result_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clock);
  endtask

  task automatic clear_rom();
    for (int a = 0; a < int'(NF); a++) begin
      rom_rect[a] = '0;
      rom_w[a]    = '0;
      rom_thr[a]  = '0;
      rom_abv[a]  = 32'd1;
      rom_blw[a]  = '0;
      rom_sthr[a] = '0;
      rom_last[a] = 1'b0;
    end
  endtask

  task automatic spot_feat(input int a, input logic [31:0] w, input logic last);
    rom_rect[a]    = '0;
    rom_rect[a][0] = {CW'(0), CW'(0), CW'(WIN), CW'(WIN)};
    rom_w[a]       = '0;
    rom_w[a][0]    = w;
    rom_thr[a]     = '0;
    rom_abv[a]     = 32'd5;
    rom_blw[a]     = -32'sd3;
    rom_last[a]    = last;
    rom_sthr[a]    = 32'd4;
  endtask

  task automatic spot_window();
    win_tb           = '0;
    win_tb[WIN][WIN] = 32'd100;
    std_tb           = 32'd1;
  endtask

  task automatic rand_setup();
    for (int a = 0; a < int'(NF); a++) begin
      for (int r = 0; r < 3; r++)
        for (int k = 0; k < 4; k++)
          rom_rect[a][r][k] = ($urandom_range(0, 19) == 0) ? CW'($urandom_range(0, 31))
                                                            : CW'($urandom_range(0, WIN));
      for (int r = 0; r < 3; r++) rom_w[a][r] = 32'($urandom_range(0, 6)) - 32'd3;
      rom_thr[a]  = 32'($urandom_range(0, 4)) - 32'd2;
      rom_abv[a]  = 32'($urandom_range(0, 40)) - 32'd10;
      rom_blw[a]  = 32'($urandom_range(0, 20)) - 32'd15;
      rom_last[a] = ($urandom_range(0, 2) == 0);
      rom_sthr[a] = 32'($urandom_range(0, 20)) - 32'd10;
    end
    for (int y = 0; y <= int'(WIN); y++)
      for (int x = 0; x <= int'(WIN); x++) win_tb[y][x] = $urandom;
    std_tb  = 32'($urandom_range(1, 8));
    stall_n = $urandom_range(0, 3);
  endtask

  // Main sequence
  initial begin
    longint ac1, ac2;
    logic [1:0][31:0] c;
    reset      = 1'b1;
    in_valid   = 1'b0;
    in_win     = '0;
    in_std_dev = '0;
    in_coord   = '0;
    in_pyr     = '0;
    clear_rom();
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_face", out_face, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_out_stages", out_stages, 0);
    chk("rst_out_accum", out_accum, 0);
    chk("rst_out_coord", out_coord, 0);
    chk("rst_out_pyr", out_pyr, 0);
    chk("rst_feat_rd_en", feat_rd_en, 0);
    chk("rst_in_ready", in_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_in_ready", in_ready, 1);

    // Single-feature stages, both pass
    spot_window();
    clear_rom();
    spot_feat(0, 32'd1, 1'b1);
    spot_feat(1, 32'd1, 1'b1);
    send_rand();
    wait_idle();

    // Negative weight: first stage rejects, no further reads
    spot_feat(0, -32'sd1, 1'b1);
    send_rand();
    wait_idle();

    // Two stages of three features, all pass
    clear_rom();
    for (int a = 0; a < 6; a++) spot_feat(a, 32'd1, (a == 2) || (a == 5));
    send_rand();
    wait_idle();

    // Long back-pressure, next window offered during DONE
    stall_n = 7;
    c       = {32'd7, 32'd9};
    send(c, 4'd3, ac1);
    begin
      int n = 0;
      while (!out_valid && n < 100) begin
        @(negedge clock);
        n++;
      end
      chk("valid_wait", out_valid, 1);
    end
    c = {32'd11, 32'd13};
    send(c, 4'd5, ac2);
    chk("accept_after_idle", ac2, hs_cyc + 1);
    stall_n = 0;
    wait_idle();

    // Out-of-range coordinate flags error; next window clears it
    rom_rect[0][1] = {CW'(0), CW'(0), CW'(31), CW'(0)};
    rom_w[0][1]    = 32'd1;
    send_rand();
    wait_idle();
    spot_feat(0, 32'd1, 1'b0);
    send_rand();
    wait_idle();

    // No stage boundaries: ROM runs out after a single stage
    clear_rom();
    for (int a = 0; a < int'(NF); a++) spot_feat(a, 32'd1, 1'b0);
    send_rand();
    wait_idle();

    // Reset while fetching feature 2
    clear_rom();
    for (int a = 0; a < 6; a++) spot_feat(a, 32'd1, (a == 2) || (a == 5));
    send_rand();
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("reset_rd_en", feat_rd_en, 0);
    chk("reset_in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    sb.delete();
    rd_log.delete();
    #1;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_back_idle", in_ready, 1);
    repeat (4) @(negedge clock);
    send_rand();
    wait_idle();

    // Randomised windows and ROMs
    for (int i = 0; i < 40; i++) begin
      rand_setup();
      send_rand();
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
